// File: rtl/data_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl_if
// Request/response bundle between the MEM stage and data_mem_ctrl.
//   req_valid/req_ready   : request handshake (accept when both are high)
//   req_we                : 1 = store, 0 = load
//   req_funct3            : RISC-V funct3 (access size and sign)
//   req_addr / req_wdata  : byte address / right-aligned store data
//   rsp_valid             : one-cycle pulse per accepted request
//   rsp_rdata / rsp_err   : extended load data / rejection flag
//   busy                  : memory clear in progress
// master = pipeline side, slave = memory controller side.
// ---------------------------------------------------------------------------
interface data_mem_ctrl_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
// Byte-addressable RV32I data memory (32-bit words, four byte lanes) with a
// valid/ready request port and a fixed-latency, in-order response pipeline.
// After reset a CLEAR state zeroes one word per cycle before requests are
// accepted.
//
// Ports:
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous active-high reset (restarts CLEAR, flushes responses)
//   bus  : data_mem_ctrl_if.slave (request, response and busy signals)
//
// Parameters:
//   ADDR_W  : decoded byte-address width (4..20), capacity 2^ADDR_W bytes
//   LATENCY : cycles from acceptance to rsp_valid (1..4)
//
// Build option:
//   MISALIGN_TRAP_EN : when defined, misaligned half/word accesses are
//                      rejected with rsp_err; otherwise the low address bits
//                      are dropped to the natural alignment of the access.
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 1
) (
    input  logic          clk,
    input  logic          rst,
    data_mem_ctrl_if.slave bus
);
    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 1 << IDX_W;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]       state_reg;
    logic [IDX_W-1:0] ptr_reg;

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_CLEAR;
            ptr_reg   <= '0;
        end else if (state_reg == ST_CLEAR) begin
            ptr_reg <= ptr_reg + IDX_W'(1);
            if (ptr_reg == IDX_W'(DEPTH - 1))
                state_reg <= ST_RUN;
        end
    end

    assign bus.req_ready = (state_reg == ST_RUN);
    assign bus.busy      = (state_reg == ST_CLEAR);

    logic accept;
    assign accept = bus.req_valid && (state_reg == ST_RUN);

    // ---------------- request decode ----------------
    logic [2:0] f3;
    logic       range_err;
    logic       f3_err;
    logic       align_err;
    logic       req_err;

    assign f3 = bus.req_funct3;

    always_comb begin
        range_err = |bus.req_addr[31:ADDR_W];
        if (bus.req_we)
            f3_err = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010);
        else
            f3_err = !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b010 ||
                       f3 == 3'b100 || f3 == 3'b101);
`ifdef MISALIGN_TRAP_EN
        // Only meaningful for legal funct3; illegal codes already error out.
        align_err = ((f3[1:0] == 2'b01) && bus.req_addr[0]) ||
                    ((f3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
        align_err = 1'b0;
`endif
        req_err = range_err || f3_err || align_err;
    end

    // ---------------- write port (shared by CLEAR and stores) ----------------
    logic [3:0]       lane_we;
    logic [31:0]      lane_wdata;
    logic [IDX_W-1:0] wr_idx;

    always_comb begin
        lane_we    = 4'b0000;
        lane_wdata = 32'h0;
        wr_idx     = bus.req_addr[ADDR_W-1:2];
        if (state_reg == ST_CLEAR) begin
            lane_we = 4'b1111;
            wr_idx  = ptr_reg;
        end else if (accept && bus.req_we && !req_err) begin
            // Replicating the data over the lanes lets the enables alone
            // pick the destination; low address bits beyond the access
            // alignment are ignored.
            case (f3[1:0])
                2'b00: begin
                    lane_we    = 4'b0001 << bus.req_addr[1:0];
                    lane_wdata = {4{bus.req_wdata[7:0]}};
                end
                2'b01: begin
                    lane_we    = bus.req_addr[1] ? 4'b1100 : 4'b0011;
                    lane_wdata = {2{bus.req_wdata[15:0]}};
                end
                default: begin
                    lane_we    = 4'b1111;
                    lane_wdata = bus.req_wdata;
                end
            endcase
        end
        if (rst)
            lane_we = 4'b0000;
    end

    // ---------------- byte-lane RAMs with registered read ----------------
    logic [31:0] rd_word;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_byte_reg;

            always_ff @(posedge clk) begin
                if (lane_we[gi])
                    mem[wr_idx] <= lane_wdata[8*gi +: 8];
                if (accept)
                    rd_byte_reg <= mem[bus.req_addr[ADDR_W-1:2]];
            end

            assign rd_word[8*gi +: 8] = rd_byte_reg;
        end
    endgenerate

    // ---------------- stage 0: request attributes alongside the read ----------------
    logic       s0_valid_reg;
    logic       s0_err_reg;
    logic       s0_we_reg;
    logic [2:0] s0_f3_reg;
    logic [1:0] s0_lane_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_reg <= 1'b0;
            s0_err_reg   <= 1'b0;
            s0_we_reg    <= 1'b0;
            s0_f3_reg    <= 3'b000;
            s0_lane_reg  <= 2'b00;
        end else begin
            s0_valid_reg <= accept;
            s0_err_reg   <= accept && req_err;
            s0_we_reg    <= bus.req_we;
            s0_f3_reg    <= f3;
            s0_lane_reg  <= bus.req_addr[1:0];
        end
    end

    // ---------------- load extraction and extension ----------------
    logic [31:0] shifted;
    logic [7:0]  sel_b;
    logic [15:0] sel_h;
    logic [31:0] rsp_rdata_next;

    always_comb begin
        shifted = rd_word >> {s0_lane_reg, 3'b000};
        sel_b   = shifted[7:0];
        sel_h   = s0_lane_reg[1] ? rd_word[31:16] : rd_word[15:0];
        case (s0_f3_reg)
            3'b000:  rsp_rdata_next = {{24{sel_b[7]}}, sel_b};
            3'b001:  rsp_rdata_next = {{16{sel_h[15]}}, sel_h};
            3'b010:  rsp_rdata_next = rd_word;
            3'b100:  rsp_rdata_next = {24'h0, sel_b};
            3'b101:  rsp_rdata_next = {16'h0, sel_h};
            default: rsp_rdata_next = 32'h0;
        endcase
        // Data is only ever non-zero on a successful load response.
        if (!s0_valid_reg || s0_err_reg || s0_we_reg)
            rsp_rdata_next = 32'h0;
    end

    // ---------------- response delay line ----------------
    logic        pipe_valid_reg [LATENCY];
    logic        pipe_err_reg   [LATENCY];
    logic [31:0] pipe_rdata_reg [LATENCY];

    generate
        for (gi = 0; gi < LATENCY; gi++) begin : g_pipe
            if (gi == 0) begin : g_head
                always_ff @(posedge clk) begin
                    if (rst) begin
                        pipe_valid_reg[gi] <= 1'b0;
                        pipe_err_reg[gi]   <= 1'b0;
                        pipe_rdata_reg[gi] <= 32'h0;
                    end else begin
                        pipe_valid_reg[gi] <= s0_valid_reg;
                        pipe_err_reg[gi]   <= s0_err_reg;
                        pipe_rdata_reg[gi] <= rsp_rdata_next;
                    end
                end
            end else begin : g_tail
                always_ff @(posedge clk) begin
                    if (rst) begin
                        pipe_valid_reg[gi] <= 1'b0;
                        pipe_err_reg[gi]   <= 1'b0;
                        pipe_rdata_reg[gi] <= 32'h0;
                    end else begin
                        pipe_valid_reg[gi] <= pipe_valid_reg[gi-1];
                        pipe_err_reg[gi]   <= pipe_err_reg[gi-1];
                        pipe_rdata_reg[gi] <= pipe_rdata_reg[gi-1];
                    end
                end
            end
        end
    endgenerate

    assign bus.rsp_valid = pipe_valid_reg[LATENCY-1];
    assign bus.rsp_err   = pipe_err_reg[LATENCY-1];
    assign bus.rsp_rdata = pipe_rdata_reg[LATENCY-1];
endmodule

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl
// Two instances (ADDR_W=6, LATENCY=1 and LATENCY=3) receive identical
// stimulus. A byte-array model predicts every response; recorded responses
// are compared for timing, data and error flag inside each scenario task.
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;
    typedef struct {
        int          cyc;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr  = 32'h0;
    logic [31:0] req_wdata = 32'h0;

    data_mem_ctrl_if if1 ();
    data_mem_ctrl_if if3 ();

    assign if1.req_valid  = req_valid;
    assign if1.req_we     = req_we;
    assign if1.req_funct3 = req_funct3;
    assign if1.req_addr   = req_addr;
    assign if1.req_wdata  = req_wdata;
    assign if3.req_valid  = req_valid;
    assign if3.req_we     = req_we;
    assign if3.req_funct3 = req_funct3;
    assign if3.req_addr   = req_addr;
    assign if3.req_wdata  = req_wdata;

    data_mem_ctrl #(.ADDR_W(6), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    data_mem_ctrl #(.ADDR_W(6), .LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   dirty    = 0;
    int   lat_of [2] = '{1, 3};
    logic [7:0] mem_model [64];
    rsp_t exp_q [$];
    rsp_t rec_q [2][$];

    always @(posedge clk) cyc <= cyc + 1;

    // Response recorder: log every rsp_valid pulse with its cycle number and
    // count any non-zero data/err seen while rsp_valid is low.
    always @(negedge clk) begin
        rsp_t r;
        if (if1.rsp_valid === 1'b1) begin
            r.cyc = cyc; r.rdata = if1.rsp_rdata; r.err = if1.rsp_err;
            rec_q[0].push_back(r);
        end else if (if1.rsp_rdata !== 32'h0 || if1.rsp_err !== 1'b0) dirty++;
        if (if3.rsp_valid === 1'b1) begin
            r.cyc = cyc; r.rdata = if3.rsp_rdata; r.err = if3.rsp_err;
            rec_q[1].push_back(r);
        end else if (if3.rsp_rdata !== 32'h0 || if3.rsp_err !== 1'b0) dirty++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [35:0] outs(input int d);
        if (d == 0) return {if1.req_ready, if1.busy, if1.rsp_valid, if1.rsp_err, if1.rsp_rdata};
        return {if3.req_ready, if3.busy, if3.rsp_valid, if3.rsp_err, if3.rsp_rdata};
    endfunction

    task automatic model_clear();
        foreach (mem_model[i]) mem_model[i] = 8'h00;
    endtask

    // Reference behaviour: byte-level memory, natural alignment, sign rules.
    task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata, output logic err);
        int          size;
        int          base;
        bit          legal;
        logic [31:0] v;
        if (we) legal = (f3 <= 3'd2);
        else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        size  = 1 << f3[1:0];
        err   = (addr >= 32'd64) || !legal;
`ifdef MISALIGN_TRAP_EN
        if (legal && (addr % size) != 0) err = 1'b1;
`endif
        rdata = 32'h0;
        if (err) return;
        base = int'(addr) - (int'(addr) % size);
        if (we) begin
            for (int i = 0; i < size; i++) mem_model[base + i] = 8'(wdata >> (8 * i));
        end else begin
            v = 32'h0;
            for (int i = 0; i < size; i++) v = v | (32'(mem_model[base + i]) << (8 * i));
            if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~((32'd1 << (8 * size)) - 32'd1);
            rdata = v;
        end
    endtask

    // Drive one request for one cycle (called right after a falling edge).
    task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata);
        rsp_t e;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        e.cyc = cyc + 1;
        model(we, f3, addr, wdata, e.rdata, e.err);
        $display("req  acc_cyc=%0d we=%0b f3=%03b addr=%08h wdata=%08h -> exp rdata=%08h err=%0b",
                 e.cyc, we, f3, addr, wdata, e.rdata, e.err);
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        int first [2] = '{-1, -1};
        int bad_busy [2] = '{0, 0};
        rsp_t e;
        rsp_t r;
        rst = 1'b1; req_valid = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (outs(d) !== {1'b0, 1'b1, 1'b0, 1'b0, 32'h0}) begin
                n_fail++;
                $display("FAIL reset_values L%0d: got %09h required %09h", lat_of[d], outs(d),
                         {1'b0, 1'b1, 1'b0, 1'b0, 32'h0});
            end
        end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int n = 0; n < 24; n++) begin
            for (int d = 0; d < 2; d++) begin
                if (first[d] < 0 && outs(d) >= 36'h8_0000_0000) first[d] = n;
                if (outs(d) >> 34 !== 36'(first[d] < 0) + 36'(first[d] >= 0) * 2) bad_busy[d]++;
            end
            @(negedge clk);
        end
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (first[d] != 16 || bad_busy[d] != 0) begin
                n_fail++;
                $display("FAIL clear_length L%0d: got %0d cycles (busy/ready errors %0d) required 16 (0)",
                         lat_of[d], first[d], bad_busy[d]);
            end
        end
        for (int w = 0; w < 16; w++) send(1'b0, 3'b010, 32'(4 * w), 32'h0);
        idle(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (rec_q[d].size() == 0) begin
                    n_fail++;
                    $display("FAIL clear_zero L%0d: no response, required cyc %0d rdata %08h err %0b",
                             lat_of[d], e.cyc + lat_of[d], e.rdata, e.err);
                end else begin
                    r = rec_q[d].pop_front();
                    if (r.cyc != e.cyc + lat_of[d] || r.rdata !== e.rdata || r.err !== e.err) begin
                        n_fail++;
                        $display("FAIL clear_zero L%0d: got cyc %0d rdata %08h err %0b required cyc %0d rdata %08h err %0b",
                                 lat_of[d], r.cyc, r.rdata, r.err, e.cyc + lat_of[d], e.rdata, e.err);
                    end
                end
            end
        end
    endtask

    task automatic test_size_sign();
        rsp_t e;
        rsp_t r;
        send(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        send(1'b0, 3'b010, 32'h10, 32'h0);
        send(1'b0, 3'b000, 32'h13, 32'h0);
        send(1'b0, 3'b100, 32'h13, 32'h0);
        send(1'b0, 3'b001, 32'h12, 32'h0);
        send(1'b0, 3'b101, 32'h10, 32'h0);
        send(1'b1, 3'b000, 32'h11, 32'hFFFFFF55);
        send(1'b1, 3'b001, 32'h12, 32'hFFFF1234);
        send(1'b0, 3'b010, 32'h10, 32'h0);
        send(1'b0, 3'b000, 32'h11, 32'h0);
        send(1'b0, 3'b101, 32'h12, 32'h0);
        idle(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (rec_q[d].size() == 0) begin
                    n_fail++;
                    $display("FAIL size_sign L%0d: no response, required cyc %0d rdata %08h err %0b",
                             lat_of[d], e.cyc + lat_of[d], e.rdata, e.err);
                end else begin
                    r = rec_q[d].pop_front();
                    if (r.cyc != e.cyc + lat_of[d] || r.rdata !== e.rdata || r.err !== e.err) begin
                        n_fail++;
                        $display("FAIL size_sign L%0d: got cyc %0d rdata %08h err %0b required cyc %0d rdata %08h err %0b",
                                 lat_of[d], r.cyc, r.rdata, r.err, e.cyc + lat_of[d], e.rdata, e.err);
                    end
                end
            end
        end
    endtask

    task automatic test_errors();
        rsp_t e;
        rsp_t r;
        send(1'b1, 3'b010, 32'h40, 32'hFFFFFFFF);
        send(1'b0, 3'b010, 32'h00, 32'h0);
        send(1'b0, 3'b011, 32'h04, 32'h0);
        send(1'b1, 3'b100, 32'h08, 32'hA5A5A5A5);
        send(1'b0, 3'b010, 32'h08, 32'h0);
        send(1'b0, 3'b010, 32'h8000_0010, 32'h0);
        send(1'b0, 3'b010, 32'h11, 32'h0);
        send(1'b0, 3'b001, 32'h13, 32'h0);
        send(1'b1, 3'b001, 32'h15, 32'h0000AAAA);
        send(1'b1, 3'b010, 32'h1B, 32'h01020304);
        send(1'b0, 3'b010, 32'h14, 32'h0);
        send(1'b0, 3'b010, 32'h18, 32'h0);
        idle(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (rec_q[d].size() == 0) begin
                    n_fail++;
                    $display("FAIL errors L%0d: no response, required cyc %0d rdata %08h err %0b",
                             lat_of[d], e.cyc + lat_of[d], e.rdata, e.err);
                end else begin
                    r = rec_q[d].pop_front();
                    if (r.cyc != e.cyc + lat_of[d] || r.rdata !== e.rdata || r.err !== e.err) begin
                        n_fail++;
                        $display("FAIL errors L%0d: got cyc %0d rdata %08h err %0b required cyc %0d rdata %08h err %0b",
                                 lat_of[d], r.cyc, r.rdata, r.err, e.cyc + lat_of[d], e.rdata, e.err);
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        rsp_t e;
        rsp_t r;
        logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        logic [2:0] f3;
        logic [31:0] addr;
        for (int w = 0; w < 4; w++) send(1'b1, 3'b010, 32'(4 * w), 32'(w + 1));
        idle(2);
        for (int w = 0; w < 4; w++) send(1'b0, 3'b010, 32'(4 * w), 32'h0);
        for (int k = 0; k < 80; k++) begin
            f3   = ($urandom_range(0, 9) < 8) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 63));
            send(1'($urandom_range(0, 1)), f3, addr, $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int d = 0; d < 2; d++) begin
                n_checks++;
                if (rec_q[d].size() == 0) begin
                    n_fail++;
                    $display("FAIL back_to_back L%0d: no response, required cyc %0d rdata %08h err %0b",
                             lat_of[d], e.cyc + lat_of[d], e.rdata, e.err);
                end else begin
                    r = rec_q[d].pop_front();
                    if (r.cyc != e.cyc + lat_of[d] || r.rdata !== e.rdata || r.err !== e.err) begin
                        n_fail++;
                        $display("FAIL back_to_back L%0d: got cyc %0d rdata %08h err %0b required cyc %0d rdata %08h err %0b",
                                 lat_of[d], r.cyc, r.rdata, r.err, e.cyc + lat_of[d], e.rdata, e.err);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        rsp_t e;
        rsp_t r;
        int   rst_cyc;
        int   first [2] = '{-1, -1};
        for (int w = 0; w < 4; w++) send(1'b1, 3'b010, 32'(4 * w), 32'(w + 1));
        for (int w = 0; w < 4; w++) send(1'b0, 3'b010, 32'(4 * w), 32'h0);
        // Reset is sampled on the edge after the last acceptance; responses
        // due on or before the last acceptance edge still appear.
        rst_cyc = cyc + 1;
        req_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int n = 0; n < 24; n++) begin
            for (int d = 0; d < 2; d++)
                if (first[d] < 0 && outs(d) >= 36'h8_0000_0000) first[d] = n;
            @(negedge clk);
        end
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (first[d] != 16) begin
                n_fail++;
                $display("FAIL midstream_clear L%0d: got %0d cycles required 16", lat_of[d], first[d]);
            end
        end
        for (int w = 0; w < 4; w++) send(1'b0, 3'b010, 32'(4 * w), 32'h0);
        idle(8);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int d = 0; d < 2; d++) begin
                if (e.cyc < rst_cyc && e.cyc + lat_of[d] >= rst_cyc) continue;
                n_checks++;
                if (rec_q[d].size() == 0) begin
                    n_fail++;
                    $display("FAIL midstream L%0d: no response, required cyc %0d rdata %08h err %0b",
                             lat_of[d], e.cyc + lat_of[d], e.rdata, e.err);
                end else begin
                    r = rec_q[d].pop_front();
                    if (r.cyc != e.cyc + lat_of[d] || r.rdata !== e.rdata || r.err !== e.err) begin
                        n_fail++;
                        $display("FAIL midstream L%0d: got cyc %0d rdata %08h err %0b required cyc %0d rdata %08h err %0b",
                                 lat_of[d], r.cyc, r.rdata, r.err, e.cyc + lat_of[d], e.rdata, e.err);
                    end
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (rec_q[d].size() != 0) begin
                n_fail++;
                $display("FAIL extra_responses L%0d: got %0d unexpected required 0", lat_of[d], rec_q[d].size());
            end
        end
        n_checks++;
        if (dirty != 0) begin
            n_fail++;
            $display("FAIL idle_outputs: got %0d cycles with nonzero rdata/err while idle required 0", dirty);
        end
    endtask

    initial begin
        test_reset();
        test_size_sign();
        test_errors();
        test_back_to_back();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
Parametrised, byte-addressable RISC-V data memory for the pipelined core's MEM stage. It is organised as 32-bit words with byte lanes. It supports all RV32I load/store sizes with sign/zero extension, a valid/ready request port, a fixed-latency pipelined response and error reporting. Reset runs a sequential clear FSM instead of a single-cycle wipe of the array.

Parameters:
- ADDR_W, 12, byte-address width actually decoded; capacity 2^ADDR_W bytes; legal range 4..20.
- DEPTH, 2^(ADDR_W-2), word count; derived, not overridden.
- LATENCY, 1, cycles from request acceptance to rsp_valid; legal range 1..4.

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 (size/sign)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- rsp_valid  out  1  response valid, one-cycle pulse per request
- rsp_rdata  out  32  load result, extended; 0 for stores and errors
- rsp_err  out  1  request rejected: range, funct3 or alignment
- busy  out  1  clear FSM active

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: req_ready=0, busy=1, rsp_valid=0, rsp_rdata=0, rsp_err=0. The response pipeline is flushed and the clear pointer is set to 0.
- FSM has two states, CLEAR and RUN. rst forces CLEAR.
- CLEAR:
  - Each cycle writes word[ptr]=0 and increments ptr.
  - When ptr==DEPTH-1, the FSM goes to RUN on the next edge.
  - Clear takes exactly DEPTH cycles after rst deasserts.
  - req_ready=0 and busy=1 throughout.
  - rst during CLEAR restarts at ptr=0.
- RUN: req_ready=1 and busy=0 every cycle. A request is accepted when req_valid && req_ready.
- Decode:
  - Word index is addr[ADDR_W-1:2]; byte lane is addr[1:0].
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Any other funct3 is an error.
- Out of range: any of addr[31:ADDR_W] nonzero gives rsp_err=1.
- Store:
  - Byte lanes are written at the accept edge.
  - SB writes lane addr[1:0] with wdata[7:0].
  - SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0], little-endian.
  - SW writes all four lanes.
- Load:
  - The word is sampled from the array at the accept edge, after any write committed on an earlier edge.
  - The selected byte or half is right-shifted; LB/LH sign-extend, LBU/LHU zero-extend.
- Errored request: no array write occurs, but a response is still produced with rsp_err=1 and rsp_rdata=0.
- Response timing:
  - Every accepted request, load or store, yields exactly one response LATENCY cycles after acceptance.
  - Responses stay in order.
  - Throughput is one request per cycle with no stalls in RUN.
- Ordering: a store accepted at edge N is visible to a load accepted at edge N+1 or later. A single port means there is no same-cycle collision.
- rsp_valid is a pulse; rsp_rdata and rsp_err are held at 0 when rsp_valid=0.
- rst mid-stream: in-flight responses are dropped, rsp_valid=0 from the next edge, and CLEAR restarts. Pre-reset stores already committed are erased by CLEAR.

Optional Feature:
Macro MISALIGN_TRAP_EN.
- Defined: a misaligned access gives rsp_err=1, no write, and rsp_rdata=0.
  - LH/LHU/SH is misaligned when addr[0]=1.
  - LW/SW is misaligned when addr[1:0]!=0.
- Undefined: the misaligned low address bits are ignored. The address is rounded down to natural alignment (half: addr[0]=0; word: addr[1:0]=0) and the access proceeds. rsp_err is then raised only for range or funct3 errors.

Test Plan:
- Reset with ADDR_W=6 (DEPTH=16): rst high 2 cycles then low -> req_ready=0 and busy=1 for exactly 16 cycles, then 1/0. LW of each of words 0x00..0x3C -> 0x00000000.
- Size/sign with LATENCY=1: SW 0xDEADBEEF @0x10, then LW 0x10 -> 0xDEADBEEF; LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF. Each response arrives 1 cycle after acceptance.
- Partial stores: after the previous scenario, SB 0x55 @0x11 then SH 0x1234 @0x12 -> LW 0x10 = 0x123455EF. The store responses have rsp_rdata=0 and rsp_err=0.
- Errors with ADDR_W=6: SW 0xFFFFFFFF @0x40 -> rsp_err=1, and a later LW 0x00 still returns 0. Load with funct3=011 -> rsp_err=1, rsp_rdata=0.
- Misalign: LW @0x11 after memory holds 0x123455EF @0x10. With MISALIGN_TRAP_EN -> rsp_err=1, rsp_rdata=0. Without it -> rsp_err=0, rsp_rdata=0x123455EF.
- Pipeline and reset with LATENCY=3: four LWs on consecutive cycles @0x00/04/08/0C holding 1/2/3/4 -> rsp_valid on 4 consecutive cycles, first 3 cycles after the first acceptance, data 1,2,3,4 in order. Repeat the stream and assert rst one cycle after the last request -> no further rsp_valid, and CLEAR runs 16 cycles.
